// File: rtl/kab_io_pkg.sv
// Shared KabIO definitions for the external interrupt controller.
// Contents:
//   EIC_PEND / EIC_ENABLE / EIC_STATUS / EIC_SWSET : word offsets of the EIC registers
//   eic_state_t                                    : request handshake state
package kab_io_pkg;

  localparam logic [1:0] EIC_PEND   = 2'd0;
  localparam logic [1:0] EIC_ENABLE = 2'd1;
  localparam logic [1:0] EIC_STATUS = 2'd2;
  localparam logic [1:0] EIC_SWSET  = 2'd3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } eic_state_t;

endpackage

// File: rtl/kab_eic_prio.sv
// Lowest-index-wins priority encoder (purely combinational).
// Ports:
//   vec   in  N     : request vector, bit i is source i
//   valid out 1     : at least one bit of vec is set
//   id    out ID_W  : index of the lowest set bit (0 when valid is low)
module kab_eic_prio #(
  parameter int N    = 8,
  parameter int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    vec,
  output logic            valid,
  output logic [ID_W-1:0] id
);

  always_comb begin
    valid = |vec;
    id    = '0;
    // Scan downwards so the last hit, the lowest index, wins.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        id = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/kab_eic.sv
// Kabeta external interrupt controller.
// Latches rising edges of the peripheral interrupt lines into pending bits,
// masks them with ENABLE, picks the lowest-index candidate and presents it to
// the core with a req/ack handshake. Registers are reachable over KabIO.
// Ports:
//   Sys_Clock   in  1        : clock
//   Sys_Reset   in  1        : synchronous active-low reset
//   Src_Irq     in  NUM_SRC  : interrupt lines (already synchronous)
//   Sys_Sel     in  1        : block select
//   Sys_Address in  2        : register word offset
//   Sys_WrEn    in  1        : write strobe
//   Sys_RdEn    in  1        : read strobe
//   Sys_WrData  in  32       : write data
//   Sys_RdData  out 32       : registered read data, held until the next read
//   EIC_IntReq  out 1        : interrupt request to the core
//   EIC_IntId   out ID_W     : source being requested
//   EIC_IntAck  in  1        : single-cycle acknowledge
module kab_eic
  import kab_io_pkg::*;
#(
  parameter int NUM_SRC = 8,
  parameter int ID_W    = $clog2(NUM_SRC)
) (
  input  logic               Sys_Clock,
  input  logic               Sys_Reset,
  input  logic [NUM_SRC-1:0] Src_Irq,
  input  logic               Sys_Sel,
  input  logic [1:0]         Sys_Address,
  input  logic               Sys_WrEn,
  input  logic               Sys_RdEn,
  input  logic [31:0]        Sys_WrData,
  output logic [31:0]        Sys_RdData,
  output logic               EIC_IntReq,
  output logic [ID_W-1:0]    EIC_IntId,
  input  logic               EIC_IntAck
);

  logic [NUM_SRC-1:0] prev_q, prev_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] enable_q, enable_d;
  eic_state_t         state_q, state_d;
  logic               req_q, req_d;
  logic [ID_W-1:0]    id_q, id_d;
  logic [31:0]        rd_data_q, rd_data_d;

  logic               wr_hit;
  logic               rd_hit;
  logic [NUM_SRC-1:0] wr_bits;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] set_bits;
  logic [NUM_SRC-1:0] clr_bits;
  logic               ack_take;
  logic [NUM_SRC-1:0] cand;
  logic               win_valid;
  logic [ID_W-1:0]    win_id;
  logic [31:0]        rd_mux;

  assign cand = pend_q & enable_q;

  kab_eic_prio #(
    .N    (NUM_SRC),
    .ID_W (ID_W)
  ) u_prio (
    .vec   (cand),
    .valid (win_valid),
    .id    (win_id)
  );

  // Pending / enable / edge-detect / read path.
  always_comb begin
    wr_hit   = Sys_Sel & Sys_WrEn;
    rd_hit   = Sys_Sel & Sys_RdEn;
    wr_bits  = Sys_WrData[NUM_SRC-1:0];
    rise     = Src_Irq & ~prev_q;
    ack_take = (state_q == REQ) & EIC_IntAck;

    set_bits = rise;
    if (wr_hit && Sys_Address == EIC_SWSET) begin
      set_bits = set_bits | wr_bits;
    end

    clr_bits = '0;
    if (wr_hit && Sys_Address == EIC_PEND) begin
      clr_bits = wr_bits;
    end
    if (ack_take) begin
      clr_bits = clr_bits | (NUM_SRC'(1) << id_q);
    end

    // Sets are applied after clears so a same-cycle set always survives.
    pend_d = (pend_q & ~clr_bits) | set_bits;
    prev_d = Src_Irq;

    enable_d = enable_q;
    if (wr_hit && Sys_Address == EIC_ENABLE) begin
      enable_d = wr_bits;
    end

    // Reads observe the pre-edge register state, so a same-cycle write is not visible.
    rd_mux = '0;
    case (Sys_Address)
      EIC_PEND:   rd_mux[NUM_SRC-1:0] = pend_q;
      EIC_ENABLE: rd_mux[NUM_SRC-1:0] = enable_q;
      EIC_STATUS: begin
        rd_mux[31]     = req_q;
        rd_mux[ID_W-1:0] = id_q;
      end
      default:    rd_mux = '0;
    endcase
    rd_data_d = rd_hit ? rd_mux : rd_data_q;
  end

  // Handshake next-state logic.
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    id_d    = id_q;
    case (state_q)
      // GAP already guarantees one low cycle on the request line, so it may
      // arbitrate directly; this lets the next request rise two cycles after the ack.
      IDLE, GAP: begin
        req_d   = 1'b0;
        state_d = IDLE;
        if (win_valid) begin
          state_d = REQ;
          req_d   = 1'b1;
          id_d    = win_id;
        end
      end
      // Id is frozen here regardless of later pending/enable changes.
      REQ: begin
        if (EIC_IntAck) begin
          state_d = GAP;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge Sys_Clock) begin
    if (!Sys_Reset) begin
      prev_q    <= '0;
      pend_q    <= '0;
      enable_q  <= '0;
      state_q   <= IDLE;
      req_q     <= 1'b0;
      id_q      <= '0;
      rd_data_q <= '0;
    end else begin
      prev_q    <= prev_d;
      pend_q    <= pend_d;
      enable_q  <= enable_d;
      state_q   <= state_d;
      req_q     <= req_d;
      id_q      <= id_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign Sys_RdData = rd_data_q;
  assign EIC_IntReq = req_q;
  assign EIC_IntId  = id_q;

endmodule

// File: tb/tb_kab_eic.sv
// Self-checking bench for kab_eic: directed scenarios followed by random
// traffic, every cycle compared against a behavioural model of the controller.
module tb_kab_eic;

  logic        clk;
  logic        rst_n;
  logic [7:0]  irq;
  logic        sel;
  logic [1:0]  addr;
  logic        wren;
  logic        rden;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        int_req;
  logic [2:0]  int_id;
  logic        ack;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [7:0]  m_pend;
  logic [7:0]  m_en;
  logic [7:0]  m_prev;
  logic        m_req;
  logic [2:0]  m_id;
  logic [31:0] m_rd;

  kab_eic #(.NUM_SRC(8)) dut (
    .Sys_Clock   (clk),
    .Sys_Reset   (rst_n),
    .Src_Irq     (irq),
    .Sys_Sel     (sel),
    .Sys_Address (addr),
    .Sys_WrEn    (wren),
    .Sys_RdEn    (rden),
    .Sys_WrData  (wdata),
    .Sys_RdData  (rdata),
    .EIC_IntReq  (int_req),
    .EIC_IntId   (int_id),
    .EIC_IntAck  (ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic int lowest(input logic [7:0] v);
    for (int i = 0; i < 8; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // One clock edge of the controller as described by its rules.
  task automatic model_edge();
    logic [7:0] sets;
    logic [7:0] clrs;
    logic [7:0] cand;
    logic       wr;
    logic       rd;
    if (!rst_n) begin
      m_pend = '0; m_en = '0; m_prev = '0;
      m_req = 1'b0; m_id = '0; m_rd = '0;
      return;
    end
    wr = sel && wren;
    rd = sel && rden;
    if (rd) begin
      case (addr)
        2'd0:    m_rd = {24'b0, m_pend};
        2'd1:    m_rd = {24'b0, m_en};
        2'd2:    m_rd = {m_req, 28'b0, m_id};
        default: m_rd = 32'b0;
      endcase
    end
    sets = irq & ~m_prev;
    if (wr && addr == 2'd3) sets = sets | wdata[7:0];
    clrs = (wr && addr == 2'd0) ? wdata[7:0] : 8'h00;
    cand = m_pend & m_en;
    if (m_req) begin
      if (ack) begin
        clrs[m_id] = 1'b1;
        m_req = 1'b0;
      end
    end else if (cand != 8'h00) begin
      m_req = 1'b1;
      m_id  = 3'(lowest(cand));
    end
    m_pend = (m_pend & ~clrs) | sets;
    if (wr && addr == 2'd1) m_en = wdata[7:0];
    m_prev = irq;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("model_req", {31'b0, int_req}, {31'b0, m_req});
    chk("model_id", {29'b0, int_id}, {29'b0, m_id});
    chk("model_rdata", rdata, m_rd);
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; wren = 1'b1; addr = a; wdata = d;
    tick();
    sel = 1'b0; wren = 1'b0;
  endtask

  task automatic bus_rd(input logic [1:0] a);
    sel = 1'b1; rden = 1'b1; addr = a;
    tick();
    sel = 1'b0; rden = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; irq = '0; sel = 1'b0; addr = '0; wren = 1'b0;
    rden = 1'b0; wdata = '0; ack = 1'b0;
    m_pend = '0; m_en = '0; m_prev = '0; m_req = 1'b0; m_id = '0; m_rd = '0;

    // Reset state
    tick();
    tick();
    chk("reset_req", {31'b0, int_req}, 32'd0);
    chk("reset_id", {29'b0, int_id}, 32'd0);
    chk("reset_rdata", rdata, 32'd0);
    rst_n = 1'b1;

    // Single source 2: pending, request, ack
    bus_wr(2'd1, 32'h04);
    irq = 8'h04;
    tick();
    irq = 8'h00;
    bus_rd(2'd0);
    chk("src2_pend", rdata, 32'h04);
    chk("src2_req", {31'b0, int_req}, 32'd1);
    chk("src2_id", {29'b0, int_id}, 32'd2);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("src2_ack_req", {31'b0, int_req}, 32'd0);
    bus_rd(2'd0);
    chk("src2_pend_clr", rdata, 32'h00);

    // Simultaneous 5 and 1
    bus_wr(2'd1, 32'hFF);
    irq = 8'h22; tick();
    irq = 8'h00; tick();
    chk("pri_first_id", {29'b0, int_id}, 32'd1);
    chk("pri_first_req", {31'b0, int_req}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("pri_gap_req", {31'b0, int_req}, 32'd0);
    tick();
    chk("pri_second_req", {31'b0, int_req}, 32'd1);
    chk("pri_second_id", {29'b0, int_id}, 32'd5);

    // Higher-priority edge while presenting id 5
    irq = 8'h01; tick();
    irq = 8'h00; tick();
    chk("hold_id", {29'b0, int_id}, 32'd5);
    chk("hold_req", {31'b0, int_req}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("hold_ack_req", {31'b0, int_req}, 32'd0);
    tick();
    chk("next_id", {29'b0, int_id}, 32'd0);
    chk("next_req", {31'b0, int_req}, 32'd1);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();
    chk("drained_req", {31'b0, int_req}, 32'd0);

    // W1C and rising edge on bit 3 in the same cycle: set wins
    sel = 1'b1; wren = 1'b1; addr = 2'd0; wdata = 32'h08; irq = 8'h08;
    tick();
    sel = 1'b0; wren = 1'b0; irq = 8'h00;
    bus_rd(2'd0);
    chk("setwins_pend", rdata, 32'h08);
    chk("setwins_id", {29'b0, int_id}, 32'd3);
    ack = 1'b1; tick(); ack = 1'b0;
    tick();

    // Software set of source 7 and STATUS readback
    bus_wr(2'd1, 32'h80);
    bus_wr(2'd3, 32'h80);
    tick();
    chk("swset_req", {31'b0, int_req}, 32'd1);
    chk("swset_id", {29'b0, int_id}, 32'd7);
    bus_rd(2'd2);
    chk("status", rdata, 32'h80000007);
    bus_rd(2'd3);
    chk("swset_reads0", rdata, 32'h0);

    // Reset during REQ, then stray acks in IDLE
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("rstreq_req", {31'b0, int_req}, 32'd0);
    bus_rd(2'd0);
    chk("rstreq_pend", rdata, 32'h0);
    bus_rd(2'd1);
    chk("rstreq_en", rdata, 32'h0);
    ack = 1'b1; tick(); tick(); ack = 1'b0;
    chk("idle_ack_req", {31'b0, int_req}, 32'd0);
    bus_rd(2'd0);
    chk("idle_ack_pend", rdata, 32'h0);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      rst_n = ($urandom_range(0, 149) != 0);
      if ($urandom_range(0, 3) == 0) irq = irq ^ 8'($urandom);
      sel   = ($urandom_range(0, 1) == 1);
      wren  = ($urandom_range(0, 3) == 0);
      rden  = ($urandom_range(0, 2) == 0);
      addr  = 2'($urandom);
      wdata = $urandom;
      ack   = ($urandom_range(0, 2) == 0);
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
